// File: rtl/paddle_ctrl.sv
// Frame-synchronous paddle position controller: debounced buttons, per-frame accelerated motion.
// Optional ball-tracking auto mode is compiled in with `define PADDLE_AUTO_EN.

module paddle_deb #(
  parameter int DEB_CYCLES = 65536
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_lvl
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_lvl;

  // Counter only runs while a change is pending; any return to the accepted level clears it.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_lvl  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_lvl <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_lvl = r_lvl;
endmodule

module paddle_ctrl #(
  parameter int          SCREEN_H   = 600,
  parameter int          PADDLE_LEN = 80,
  parameter int          Y_INIT     = 260,
  parameter int          STEP_MAX   = 8,
  parameter int          DEB_CYCLES = 65536,
  parameter logic [11:0] COLOR      = 12'hFFF
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vblnk_in,
  input  logic        btn_up,
  input  logic        btn_down,
`ifdef PADDLE_AUTO_EN
  input  logic [11:0] ball_y,
  input  logic        auto_mode,
`endif
  output logic [11:0] y_pos,
  output logic [11:0] color_out,
  output logic        at_top,
  output logic        at_bottom
);
  localparam int                SW   = $clog2(STEP_MAX + 1);
  localparam logic signed [12:0] YMAX = 13'(SCREEN_H - PADDLE_LEN);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  state_t              r_state, w_state_nx;
  logic [SW-1:0]       r_speed, w_speed_nx;
  logic [11:0]         r_y;
  logic                r_top, r_bot;
  logic                r_vb, r_vb_d, r_tick;
  logic [1:0]          w_raw, w_lvl;
  logic signed [12:0]  w_cur, w_stp, w_sum, w_y_nx;

  assign w_raw = {btn_down, btn_up};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_deb
      paddle_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .pclk  (pclk),
        .rst_n (rst_n),
        .i_raw (w_raw[g]),
        .o_lvl (w_lvl[g])
      );
    end
  endgenerate

  // Rising vblnk edge -> one-cycle registered tick; position moves on the cycle after it.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vb   <= 1'b0;
      r_vb_d <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_vb   <= vblnk_in;
      r_vb_d <= r_vb;
      r_tick <= r_vb & ~r_vb_d;
    end
  end

`ifdef PADDLE_AUTO_EN
  localparam logic signed [12:0] HALF = 13'(STEP_MAX / 2);
  logic signed [12:0] w_tgt, w_diff, w_mag, w_amt;
`endif

  always_comb begin
    w_state_nx = S_IDLE;
    w_speed_nx = '0;
    w_cur      = signed'({1'b0, r_y});
    w_stp      = '0;
    w_sum      = w_cur;
    w_y_nx     = w_cur;
    case (w_lvl)
      2'b01: begin
        w_state_nx = S_UP;
        w_speed_nx = (r_state != S_UP) ? SW'(1) :
                     (r_speed >= SW'(STEP_MAX)) ? SW'(STEP_MAX) : r_speed + SW'(1);
        w_stp      = signed'(13'(w_speed_nx));
        w_sum      = w_cur - w_stp;
        w_y_nx     = (w_sum < 13'sd0) ? 13'sd0 : w_sum;
      end
      2'b10: begin
        w_state_nx = S_DOWN;
        w_speed_nx = (r_state != S_DOWN) ? SW'(1) :
                     (r_speed >= SW'(STEP_MAX)) ? SW'(STEP_MAX) : r_speed + SW'(1);
        w_stp      = signed'(13'(w_speed_nx));
        w_sum      = w_cur + w_stp;
        w_y_nx     = (w_sum > YMAX) ? YMAX : w_sum;
      end
      default: ;
    endcase
`ifdef PADDLE_AUTO_EN
    w_tgt  = signed'({1'b0, ball_y}) - signed'(13'(PADDLE_LEN / 2));
    w_tgt  = (w_tgt < 13'sd0) ? 13'sd0 : (w_tgt > YMAX) ? YMAX : w_tgt;
    w_diff = w_tgt - w_cur;
    w_mag  = (w_diff < 13'sd0) ? -w_diff : w_diff;
    w_amt  = (w_mag > HALF) ? HALF : w_mag;
    if (auto_mode) begin
      w_speed_nx = '0;
      if (w_diff < 13'sd0) begin
        w_state_nx = S_UP;
        w_y_nx     = w_cur - w_amt;
      end else if (w_diff > 13'sd0) begin
        w_state_nx = S_DOWN;
        w_y_nx     = w_cur + w_amt;
      end else begin
        w_state_nx = S_IDLE;
        w_y_nx     = w_cur;
      end
    end
`endif
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_speed <= '0;
      r_y     <= 12'(Y_INIT);
      r_top   <= 1'b0;
      r_bot   <= 1'b0;
    end else if (r_tick) begin
      r_state <= w_state_nx;
      r_speed <= w_speed_nx;
      r_y     <= w_y_nx[11:0];
      r_top   <= (w_y_nx == 13'sd0);
      r_bot   <= (w_y_nx == YMAX);
    end
  end

  assign y_pos     = r_y;
  assign at_top    = r_top;
  assign at_bottom = r_bot;
  assign color_out = COLOR;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: stimulus queues expected y_pos per frame, monitor checks after each tick.

module tb_paddle_ctrl;
  logic        pclk = 1'b0, rst_n = 1'b0, vblnk_in = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [11:0] y_pos, color_out;
  logic        at_top, at_bottom;

  int          n_chk = 0, n_fail = 0;
  logic [11:0] exp_q[$];
  int          my = 260, ms = 0, mst = 0;
  int          up9[9] = '{259, 257, 254, 250, 245, 239, 232, 224, 216};

  always #5 pclk = ~pclk;

  paddle_ctrl #(.DEB_CYCLES(4)) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .vblnk_in  (vblnk_in),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .y_pos     (y_pos),
    .color_out (color_out),
    .at_top    (at_top),
    .at_bottom (at_bottom)
  );

  task automatic chk(input string nm, input logic [11:0] y);
    logic et, eb;
    et = (y == 12'd0);
    eb = (y == 12'd520);
    n_chk++;
    if (y_pos !== y || at_top !== et || at_bottom !== eb || color_out !== 12'hFFF) begin
      n_fail++;
      $display("FAIL %s: got y=%0d top=%b bot=%b col=%h, want y=%0d top=%b bot=%b col=fff",
               nm, y_pos, at_top, at_bottom, color_out, y, et, eb);
    end
  endtask

  // Monitor: y_pos is settled three edges after vblnk rises.
  initial forever begin
    @(posedge vblnk_in);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame: got y=%0d with no expected entry queued", y_pos);
    end else begin
      chk("frame", exp_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  task automatic frame();
    @(negedge pclk);
    vblnk_in = 1'b1;
    repeat (5) @(negedge pclk);
    vblnk_in = 1'b0;
    repeat (15) @(negedge pclk);
  endtask

  task automatic pf(input int y);
    exp_q.push_back(12'(y));
    frame();
  endtask

  // dir: 0 idle, 1 up, 2 down
  task automatic mf(input int dir);
    if (dir == 0) begin
      mst = 0;
      ms  = 0;
    end else begin
      ms  = (mst == dir) ? ((ms < 8) ? ms + 1 : 8) : 1;
      mst = dir;
      if (dir == 1) my = (my - ms < 0) ? 0 : my - ms;
      else          my = (my + ms > 520) ? 520 : my + ms;
    end
    pf(my);
  endtask

  task automatic settle();
    repeat (10) @(negedge pclk);
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    chk("reset", 12'd260);
    rst_n = 1'b1;
    repeat (5) @(negedge pclk);
    repeat (3) pf(260);

    btn_up = 1'b1;
    settle();
    for (int i = 0; i < 9; i++) pf(up9[i]);
    my = 216; ms = 8; mst = 1;
    while (my > 0) mf(1);
    mf(1);
    mf(1);

    btn_up = 1'b0;
    btn_down = 1'b1;
    settle();
    while (my < 520) mf(2);
    mf(2);
    mf(2);

    btn_down = 1'b0;
    btn_up = 1'b1;
    settle();
    pf(519); pf(517); pf(514);

    btn_down = 1'b1;
    settle();
    repeat (3) pf(514);
    btn_up = 1'b0;
    settle();
    pf(515); pf(517); pf(520);

    btn_down = 1'b0;
    settle();
    pf(520);
    btn_up = 1'b1;
    repeat (3) @(negedge pclk);
    btn_up = 1'b0;
    settle();
    pf(520);

    btn_up = 1'b1;
    settle();
    pf(519); pf(517); pf(514); pf(510); pf(505);
    @(negedge pclk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 12'd260);
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    settle();
    pf(259); pf(257);

    repeat (10) @(negedge pclk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected frames unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
